// File: rtl/hs32_dma_if.sv
// Single-beat request/acknowledge bus between the copy engine and its memory responder.
interface hs32_dma_if;
  logic [31:0] addr;
  logic        rw;
  logic [31:0] dout;
  logic [31:0] din;
  logic        stb;
  logic        ack;

  modport master (output addr, rw, dout, stb, input din, ack);
  modport slave  (input addr, rw, dout, stb, output din, ack);
endinterface

// File: rtl/hs32_dma.sv
// Word-by-word memory copy engine: read one word, write it, repeat, with abort and ack timeout.
module hs32_dma #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [15:0] len,
  hs32_dma_if.master  bus,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        err,
  output logic [15:0] count
);

  // The wait counter only needs to hold 0..TIMEOUT-1; the TIMEOUT-th idle cycle trips the error.
  localparam int unsigned    TmoW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     buf_q, buf_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            aborted_q, aborted_d;
  logic            abort_now;

  assign abort_now = pend_q | abort;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    count_d   = count_q;
    buf_d     = buf_q;
    tmo_d     = tmo_q;
    pend_d    = pend_q;
    err_d     = err_q;
    aborted_d = aborted_q;

    if (abort && (state_q inside {StRdReq, StRdWait, StWrReq, StWrWait})) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StErr: begin
        if (start) begin
          src_d     = src;
          dst_d     = dst;
          rem_d     = len;
          count_d   = '0;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = (len == 16'd0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        tmo_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (bus.ack) begin
          buf_d   = bus.din;
          state_d = abort_now ? StDone : StWrReq;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrReq: begin
        tmo_d   = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (bus.ack) begin
          count_d = count_q + 16'd1;
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - 16'd1;
          state_d = ((rem_q == 16'd1) || abort_now) ? StDone : StRdReq;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        aborted_d = pend_q;
        pend_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      tmo_q     <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      buf_q     <= buf_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Bus outputs decode from state so request values stay put until the matching ack.
  always_comb begin
    bus.stb  = 1'b0;
    bus.rw   = 1'b0;
    bus.addr = '0;
    bus.dout = '0;
    unique case (state_q)
      StRdReq: begin
        bus.stb  = 1'b1;
        bus.addr = src_q;
      end
      StRdWait: bus.addr = src_q;
      StWrReq: begin
        bus.stb  = 1'b1;
        bus.rw   = 1'b1;
        bus.addr = dst_q;
        bus.dout = buf_q;
      end
      StWrWait: begin
        bus.rw   = 1'b1;
        bus.addr = dst_q;
        bus.dout = buf_q;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle) && (state_q != StErr);
  assign done    = (state_q == StDone);
  assign aborted = aborted_q;
  assign err     = err_q;
  assign count   = count_q;

endmodule

// File: tb/tb_hs32_dma.sv
// Scoreboard bench for hs32_dma: a transaction-list model feeds a queue checked by a bus monitor.
module tb_hs32_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy_w, done_w, aborted_w, err_w;
  logic [15:0] count_w;

  hs32_dma_if bus ();

  hs32_dma #(.TIMEOUT(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .bus     (bus),
    .busy    (busy_w),
    .done    (done_w),
    .aborted (aborted_w),
    .err     (err_w),
    .count   (count_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_err = 0;
  int          done_seen = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic        prev_stb = 1'b0;
  bit          resp_en, stray_req, flush_req;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Backing memory: unwritten words hold an address-derived pattern.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000 ^ (a << 7);
  endfunction

  // Monitor: every strobe must match the head of the expected queue.
  always begin
    txn_t t;
    @(posedge clk);
    #1;
    if (done_w) done_seen++;
    if (bus.stb) begin
      chk("stb_not_back_to_back", {31'b0, prev_stb}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_stb: got addr 0x%08h rw %0b expected no transaction",
                 bus.addr, bus.rw);
      end else begin
        t = exp_q.pop_front();
        chk("bus_rw", {31'b0, bus.rw}, {31'b0, t.rw});
        chk("bus_addr", bus.addr, t.addr);
        if (t.rw) chk("bus_dout", bus.dout, t.data);
      end
      if (bus.rw) wr_seen++;
      else rd_seen++;
    end
    prev_stb = bus.stb;
  end

  // Responder: acks each strobe after 0..2 extra cycles, checking the request is held.
  initial begin
    int          wait_cnt;
    logic [31:0] p_addr, p_data;
    logic        p_rw;
    bus.ack  = 1'b0;
    bus.din  = '0;
    wait_cnt = -1;
    p_addr   = '0;
    p_data   = '0;
    p_rw     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
      bus.din = $urandom;
      if (flush_req) begin
        wait_cnt  = -1;
        flush_req = 1'b0;
      end
      if (stray_req) begin
        bus.ack   = 1'b1;
        stray_req = 1'b0;
      end else if (wait_cnt == 0) begin
        chk("hold_addr_in_wait", bus.addr, p_addr);
        chk("hold_rw_in_wait", {31'b0, bus.rw}, {31'b0, p_rw});
        if (p_rw) chk("hold_dout_in_wait", bus.dout, p_data);
        bus.ack = 1'b1;
        if (p_rw) mem[p_addr] = p_data;
        else bus.din = mem_rd(p_addr);
        wait_cnt = -1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      if (bus.stb && resp_en) begin
        p_addr   = bus.addr;
        p_rw     = bus.rw;
        p_data   = bus.dout;
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: a copy is the list read(src+4i), write(dst+4i, mem[src+4i]); an abort in the
  // second read wait truncates it after that read.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int l, input bit ab);
    int d0, rd0, arm, cyc, exp_cnt;
    exp_cnt = ab ? 1 : l;
    for (int i = 0; i < l; i++) begin
      if (ab && i > 1) break;
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'd0});
      if (ab && i == 1) break;
      exp_q.push_back('{1'b1, d + 32'(4 * i), mem_rd(s + 32'(4 * i))});
    end
    d0    = done_seen;
    rd0   = rd_seen;
    arm   = 0;
    src   = s;
    dst   = d;
    len   = 16'(l);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_err", {31'b0, err_w}, 32'd0);
    chk("start_clears_aborted", {31'b0, aborted_w}, 32'd0);
    if (l == 0) chk("zero_len_done_next_cycle", {31'b0, done_w}, 32'd1);
    cyc = 0;
    while (done_seen == d0 && !err_w && cyc < 400) begin
      if (ab && arm == 0 && rd_seen == rd0 + 2) arm = 1;
      else if (arm == 1) begin
        abort = 1'b1;
        arm   = 2;
      end else if (arm == 2) begin
        abort = 1'b0;
        arm   = 3;
      end
      step();
      cyc++;
    end
    abort = 1'b0;
    chk("copy_done_within_budget", (cyc < 400) ? 32'd1 : 32'd0, 32'd1);
    step();
    step();
    chk("done_pulse_count", 32'(done_seen - d0), 32'd1);
    chk("final_count", {16'b0, count_w}, 32'(exp_cnt));
    chk("final_aborted", {31'b0, aborted_w}, {31'b0, ab});
    chk("final_err", {31'b0, err_w}, 32'd0);
    chk("final_busy", {31'b0, busy_w}, 32'd0);
    chk("expected_txns_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0, rd0, w0, cyc;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    resp_en = 1'b1;
    stray_req = 1'b0;
    flush_req = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_stb", {31'b0, bus.stb}, 32'd0);
    chk("reset_busy", {31'b0, busy_w}, 32'd0);
    chk("reset_done", {31'b0, done_w}, 32'd0);
    chk("reset_err", {31'b0, err_w}, 32'd0);
    chk("reset_addr", bus.addr, 32'd0);
    chk("reset_count", {16'b0, count_w}, 32'd0);
    reset = 1'b0;
    step();

    do_copy(32'h0000_0100, 32'h0000_0200, 3, 1'b0);
    do_copy(32'h0000_0700, 32'h0000_0300, 0, 1'b0);
    do_copy(32'hFFFF_FFFC, 32'h0000_0400, 2, 1'b0);
    do_copy(32'h0000_3000, 32'h0002_0000, 4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      do_copy(32'h1000 + (32'($urandom_range(0, 15)) << 8),
              32'h10000 + (32'($urandom_range(0, 15)) << 8), int'($urandom_range(1, 6)), 1'b0);
    end

    // Timeout: no responder, err must appear exactly 8 cycles into the read wait.
    resp_en = 1'b0;
    exp_q.push_back('{1'b0, 32'h0000_5000, 32'd0});
    d0    = done_seen;
    rd0   = rd_seen;
    src   = 32'h0000_5000;
    dst   = 32'h0000_6000;
    len   = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (rd_seen == rd0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("timeout_read_issued", 32'(rd_seen - rd0), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) chk("timeout_err_not_early", {31'b0, err_w}, 32'd0);
    end
    chk("timeout_err_set", {31'b0, err_w}, 32'd1);
    chk("timeout_busy_low", {31'b0, busy_w}, 32'd0);
    repeat (3) step();
    chk("timeout_no_done", 32'(done_seen - d0), 32'd0);
    chk("timeout_err_held", {31'b0, err_w}, 32'd1);
    resp_en = 1'b1;
    do_copy(32'h0000_5000, 32'h0000_6000, 2, 1'b0);

    // Reset in the first write wait, then a stray ack while idle.
    exp_q.push_back('{1'b0, 32'h0000_7000, 32'd0});
    exp_q.push_back('{1'b1, 32'h0000_8000, mem_rd(32'h0000_7000)});
    w0    = wr_seen;
    src   = 32'h0000_7000;
    dst   = 32'h0000_8000;
    len   = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (wr_seen == w0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("reset_test_write_issued", 32'(wr_seen - w0), 32'd1);
    step();
    reset = 1'b1;
    flush_req = 1'b1;
    #1;
    chk("midreset_stb", {31'b0, bus.stb}, 32'd0);
    chk("midreset_rw", {31'b0, bus.rw}, 32'd0);
    chk("midreset_busy", {31'b0, busy_w}, 32'd0);
    chk("midreset_addr", bus.addr, 32'd0);
    chk("midreset_dout", bus.dout, 32'd0);
    chk("midreset_count", {16'b0, count_w}, 32'd0);
    chk("midreset_flags", {29'b0, done_w, err_w, aborted_w}, 32'd0);
    exp_q.delete();
    repeat (3) step();
    reset = 1'b0;
    d0 = done_seen;
    repeat (5) step();
    chk("after_reset_idle", {31'b0, busy_w}, 32'd0);
    stray_req = 1'b1;
    repeat (4) step();
    chk("stray_ack_busy", {31'b0, busy_w}, 32'd0);
    chk("stray_ack_count", {16'b0, count_w}, 32'd0);
    chk("stray_ack_no_done", 32'(done_seen - d0), 32'd0);
    chk("stray_ack_err", {31'b0, err_w}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
